mem_port_arbiter: RTL and testbench

- Shares one single-port unified memory between the CPU fetch stage (I-port) and the memory stage (D-port).
- Sequences each memory transaction over a fixed number of wait cycles and returns read data with a one-cycle acknowledge.
- Drives a pipeline stall while either port has an unacknowledged request.
- Sits between the cpu pipeline and the memory model; clocked by clk, reset by clrn.

---
 rtl/mem_port_arbiter_if.sv | 35 +++
 rtl/mem_port_arbiter.sv | 96 +++++++++
 tb/tb_mem_port_arbiter.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle between the CPU I/D request ports, the shared memory port and the stall line.
// Latency and backpressure are set by the arbiter: each request is held until its ack, and stall covers the wait.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_ack;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ack;
  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic          stall;

  // Arbiter side
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    output i_rdata, i_ack, d_rdata, d_ack, m_en, m_we, m_addr, m_wdata, stall
  );

  // Pipeline/memory side
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  i_rdata, i_ack, d_rdata, d_ack, m_en, m_we, m_addr, m_wdata, stall
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates I-fetch and D-access onto one single-port memory, D-priority with a bounded D burst.
// Grant edge -> m_en for LAT cycles -> one-cycle ack; requesters hold req and see stall until acked.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int LAT     = 2,
  parameter int D_BURST = 2
) (
  input  logic               clk,
  input  logic               clrn,
  mem_port_arbiter_if.slave  bus
);

  localparam logic [3:0] CNT_LOAD  = 4'(LAT - 1);
  localparam logic [1:0] BURST_MAX = 2'(D_BURST);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  logic          owner_d;
  logic [3:0]    cnt;
  logic [1:0]    dstreak;

  logic          grant_i;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic [1:0]    streak_nxt;

  always_comb begin
    grant_i    = bus.i_req && (!bus.d_req || (dstreak == BURST_MAX));
    sel_addr   = grant_i ? bus.i_addr : bus.d_addr;
    // A fetch leaves the write-data register untouched.
    sel_wdata  = grant_i ? bus.m_wdata : bus.d_wdata;
    sel_we     = !grant_i && bus.d_we;
    streak_nxt = '0;
    if (!grant_i && bus.i_req) begin
      streak_nxt = (dstreak == BURST_MAX) ? dstreak : dstreak + 2'd1;
    end
  end

  assign bus.stall = (bus.i_req & ~bus.i_ack) | (bus.d_req & ~bus.d_ack);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state       <= IDLE;
      cnt         <= '0;
      owner_d     <= 1'b0;
      dstreak     <= '0;
      bus.m_en    <= 1'b0;
      bus.m_we    <= 1'b0;
      bus.m_addr  <= '0;
      bus.m_wdata <= '0;
      bus.i_rdata <= '0;
      bus.d_rdata <= '0;
      bus.i_ack   <= 1'b0;
      bus.d_ack   <= 1'b0;
    end else begin
      bus.i_ack <= 1'b0;
      bus.d_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_req || bus.d_req) begin
            owner_d     <= !grant_i;
            dstreak     <= streak_nxt;
            bus.m_addr  <= sel_addr;
            bus.m_wdata <= sel_wdata;
            bus.m_we    <= sel_we;
            bus.m_en    <= 1'b1;
            cnt         <= CNT_LOAD;
            state       <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state    <= DONE;
            bus.m_en <= 1'b0;
            bus.m_we <= 1'b0;
            if (owner_d) begin
              if (!bus.m_we) bus.d_rdata <= bus.m_rdata;
              bus.d_ack <= 1'b1;
            end else begin
              bus.i_rdata <= bus.m_rdata;
              bus.i_ack   <= 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int LAT = 2;
  localparam int DB  = 2;

  logic clk;
  logic clrn;
  int   n_chk  = 0;
  int   n_pass = 0;

  mem_port_arbiter_if #(.AW(32), .DW(32)) b0 ();
  mem_port_arbiter_if #(.AW(32), .DW(32)) b1 ();

  mem_port_arbiter #(.AW(32), .DW(32), .LAT(LAT), .D_BURST(DB)) u_dut0 (
    .clk(clk), .clrn(clrn), .bus(b0)
  );
  mem_port_arbiter #(.AW(32), .DW(32), .LAT(1), .D_BURST(DB)) u_dut1 (
    .clk(clk), .clrn(clrn), .bus(b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return 32'h8C01_0000 ^ ((a - 32'd4) * 32'h0010_0001);
  endfunction

  // Memory seen by the LAT=2 instance; unwritten words read back as dflt(addr).
  logic [31:0] mem0 [64] = '{default: '0};
  logic        wv0  [64] = '{default: 1'b0};
  always @(posedge clk) begin
    if (b0.m_en && b0.m_we) begin
      mem0[b0.m_addr[7:2]] <= b0.m_wdata;
      wv0[b0.m_addr[7:2]]  <= 1'b1;
    end
  end
  assign b0.m_rdata = wv0[b0.m_addr[7:2]] ? mem0[b0.m_addr[7:2]] : dflt(b0.m_addr);
  assign b1.m_rdata = dflt(b1.m_addr);

  // Reference memory contents for the randomized run
  logic [31:0] ref_mem [logic [31:0]];
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  task automatic idle_inputs();
    b0.i_req = 0; b0.i_addr = '0; b0.d_req = 0; b0.d_we = 0; b0.d_addr = '0; b0.d_wdata = '0;
    b1.i_req = 0; b1.i_addr = '0; b1.d_req = 0; b1.d_we = 0; b1.d_addr = '0; b1.d_wdata = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    clrn = 1'b0;
    repeat (2) @(negedge clk);
    clrn = 1'b1;
  endtask

  task automatic test_reset();
    logic [132:0] v;
    clrn = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    v = {b0.m_en, b0.m_we, b0.m_addr, b0.m_wdata, b0.i_rdata, b0.d_rdata, b0.i_ack, b0.d_ack, b0.stall};
    n_chk++; if (v !== '0) $display("FAIL reset_dut0 got=%h exp=0", v); else n_pass++;
    v = {b1.m_en, b1.m_we, b1.m_addr, b1.m_wdata, b1.i_rdata, b1.d_rdata, b1.i_ack, b1.d_ack, b1.stall};
    n_chk++; if (v !== '0) $display("FAIL reset_dut1 got=%h exp=0", v); else n_pass++;
    clrn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_chk++; if (b0.m_en !== 1'b0) $display("FAIL reset_idle_m_en cyc=%0d got=%b exp=0", c, b0.m_en); else n_pass++;
    end
  endtask

  task automatic test_single_fetch();
    apply_reset();
    b0.i_req = 1; b0.i_addr = 32'h04;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clk);
      n_chk++; if (b0.m_en !== (cyc <= 2)) $display("FAIL fetch_m_en cyc=%0d got=%b exp=%b", cyc, b0.m_en, cyc <= 2); else n_pass++;
      n_chk++; if (b0.i_ack !== (cyc == 3)) $display("FAIL fetch_i_ack cyc=%0d got=%b exp=%b", cyc, b0.i_ack, cyc == 3); else n_pass++;
      n_chk++; if (b0.stall !== (cyc <= 2)) $display("FAIL fetch_stall cyc=%0d got=%b exp=%b", cyc, b0.stall, cyc <= 2); else n_pass++;
      if (cyc <= 2) begin
        n_chk++; if (b0.m_addr !== 32'h04 || b0.m_we !== 1'b0)
          $display("FAIL fetch_m_addr cyc=%0d got=%h/%b exp=00000004/0", cyc, b0.m_addr, b0.m_we); else n_pass++;
      end
      if (cyc == 3) begin
        n_chk++; if (b0.i_rdata !== 32'h8C01_0000) $display("FAIL fetch_i_rdata got=%h exp=8c010000", b0.i_rdata); else n_pass++;
        b0.i_req = 0;
      end
    end
  endtask

  task automatic test_store_load();
    logic exp_en, exp_we, exp_ack;
    apply_reset();
    b0.d_req = 1; b0.d_we = 1; b0.d_addr = 32'h40; b0.d_wdata = 32'hDEAD_BEEF;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      exp_en  = (cyc == 1 || cyc == 2 || cyc == 5 || cyc == 6);
      exp_we  = (cyc <= 2);
      exp_ack = (cyc == 3 || cyc == 7);
      n_chk++; if (b0.m_en !== exp_en) $display("FAIL sl_m_en cyc=%0d got=%b exp=%b", cyc, b0.m_en, exp_en); else n_pass++;
      n_chk++; if (b0.m_we !== exp_we) $display("FAIL sl_m_we cyc=%0d got=%b exp=%b", cyc, b0.m_we, exp_we); else n_pass++;
      n_chk++; if (b0.d_ack !== exp_ack) $display("FAIL sl_d_ack cyc=%0d got=%b exp=%b", cyc, b0.d_ack, exp_ack); else n_pass++;
      if (cyc <= 2) begin
        n_chk++; if (b0.m_wdata !== 32'hDEAD_BEEF || b0.m_addr !== 32'h40)
          $display("FAIL sl_wr_bus cyc=%0d got=%h@%h exp=deadbeef@00000040", cyc, b0.m_wdata, b0.m_addr); else n_pass++;
      end
      if (cyc == 3) begin
        n_chk++; if (b0.d_rdata !== 32'h0) $display("FAIL sl_rdata_after_write got=%h exp=0", b0.d_rdata); else n_pass++;
        b0.d_we = 0;
      end
      if (cyc == 7) begin
        n_chk++; if (b0.d_rdata !== 32'hDEAD_BEEF) $display("FAIL sl_load_rdata got=%h exp=deadbeef", b0.d_rdata); else n_pass++;
        b0.d_req = 0;
      end
    end
  endtask

  task automatic test_reset_midwrite();
    logic [132:0] v;
    b0.d_req = 1; b0.d_we = 1; b0.d_addr = 32'hFC; b0.d_wdata = 32'h1234_5678;
    repeat (2) @(negedge clk);
    n_chk++; if (b0.m_we !== 1'b1) $display("FAIL mid_pre_m_we got=%b exp=1", b0.m_we); else n_pass++;
    clrn = 1'b0;
    b0.d_req = 0;
    #1;
    v = {b0.m_en, b0.m_we, b0.m_addr, b0.m_wdata, b0.i_rdata, b0.d_rdata, b0.i_ack, b0.d_ack, b0.stall};
    n_chk++; if (v !== '0) $display("FAIL mid_async_clear got=%h exp=0", v); else n_pass++;
    repeat (2) @(negedge clk);
    clrn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_chk++; if (b0.m_en !== 1'b0 || b0.d_ack !== 1'b0)
        $display("FAIL mid_after_release cyc=%0d got=%b/%b exp=0/0", c, b0.m_en, b0.d_ack); else n_pass++;
    end
    b0.i_req = 1; b0.i_addr = 32'h08;
    @(negedge clk);
    n_chk++; if (b0.m_en !== 1'b1 || b0.m_addr !== 32'h08)
      $display("FAIL mid_idle_grant got=%b@%h exp=1@00000008", b0.m_en, b0.m_addr); else n_pass++;
    repeat (2) @(negedge clk);
    b0.i_req = 0;
    @(negedge clk);
  endtask

  task automatic test_contention();
    string exp_s = "DDIDDI";
    byte   q[$];
    apply_reset();
    b0.i_req = 1; b0.i_addr = 32'h10;
    b0.d_req = 1; b0.d_we = 0; b0.d_addr = 32'h20;
    for (int c = 0; c < 60 && q.size() < 6; c++) begin
      @(negedge clk);
      if (b0.i_ack) q.push_back("I");
      if (b0.d_ack) q.push_back("D");
    end
    b0.i_req = 0; b0.d_req = 0;
    n_chk++; if (q.size() != 6) $display("FAIL cont_count got=%0d exp=6", q.size()); else n_pass++;
    for (int i = 0; i < q.size() && i < 6; i++) begin
      n_chk++; if (q[i] != exp_s[i]) $display("FAIL cont_order idx=%0d got=%c exp=%c", i, q[i], exp_s[i]); else n_pass++;
    end
    repeat (LAT + 2) @(negedge clk);
  endtask

  task automatic test_random();
    int k = 0, kn, streak = 0;
    bit own_d = 0, gw = 0, exp_en, exp_ia, exp_da, exp_st;
    logic [31:0] ga = '0, gd = '0, last_drd = '0;
    apply_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      // Predict what the upcoming edge does from the transaction-timing rules.
      if (k == 0 && (b0.i_req || b0.d_req)) begin
        own_d = b0.d_req && !(b0.i_req && streak == DB);
        if (own_d) begin
          streak = b0.i_req ? streak + 1 : 0;
          ga = b0.d_addr; gw = b0.d_we; gd = b0.d_wdata;
        end else begin
          streak = 0; ga = b0.i_addr; gw = 0;
        end
        kn = 1;
      end else if (k > 0 && k <= LAT) kn = k + 1;
      else kn = 0;
      @(negedge clk);
      k = kn;
      exp_en = (k >= 1 && k <= LAT);
      exp_ia = (k == LAT + 1) && !own_d;
      exp_da = (k == LAT + 1) && own_d;
      exp_st = (b0.i_req && !exp_ia) || (b0.d_req && !exp_da);
      n_chk++; if (b0.m_en !== exp_en) $display("FAIL rnd_m_en cyc=%0d got=%b exp=%b", cyc, b0.m_en, exp_en); else n_pass++;
      n_chk++; if ({b0.i_ack, b0.d_ack} !== {exp_ia, exp_da})
        $display("FAIL rnd_acks cyc=%0d got=%b%b exp=%b%b", cyc, b0.i_ack, b0.d_ack, exp_ia, exp_da); else n_pass++;
      n_chk++; if (b0.stall !== exp_st) $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", cyc, b0.stall, exp_st); else n_pass++;
      if (exp_en) begin
        n_chk++; if (b0.m_addr !== ga || b0.m_we !== gw)
          $display("FAIL rnd_m_bus cyc=%0d got=%h/%b exp=%h/%b", cyc, b0.m_addr, b0.m_we, ga, gw); else n_pass++;
        if (gw) begin
          n_chk++; if (b0.m_wdata !== gd) $display("FAIL rnd_m_wdata cyc=%0d got=%h exp=%h", cyc, b0.m_wdata, gd); else n_pass++;
        end
      end
      if (exp_ia) begin
        n_chk++; if (b0.i_rdata !== ref_rd(ga)) $display("FAIL rnd_i_rdata cyc=%0d got=%h exp=%h", cyc, b0.i_rdata, ref_rd(ga)); else n_pass++;
      end
      if (exp_da) begin
        if (gw) ref_mem[ga] = gd;
        else last_drd = ref_rd(ga);
        n_chk++; if (b0.d_rdata !== last_drd) $display("FAIL rnd_d_rdata cyc=%0d got=%h exp=%h", cyc, b0.d_rdata, last_drd); else n_pass++;
      end
      if (!b0.i_req || exp_ia) begin
        b0.i_req = ($urandom_range(0, 2) != 0);
        if (b0.i_req) b0.i_addr = 32'($urandom_range(0, 15)) << 2;
      end
      if (!b0.d_req || exp_da) begin
        b0.d_req = ($urandom_range(0, 2) != 0);
        if (b0.d_req) begin
          b0.d_addr  = 32'($urandom_range(0, 15)) << 2;
          b0.d_we    = 1'($urandom_range(0, 1));
          b0.d_wdata = $urandom;
        end
      end
    end
    b0.i_req = 0; b0.d_req = 0;
    repeat (LAT + 2) @(negedge clk);
  endtask

  task automatic test_lat1_back_to_back();
    int last = -1, nack = 0;
    apply_reset();
    b1.i_req = 1; b1.i_addr = 32'h08;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      n_chk++; if (b1.m_en && b1.i_ack) $display("FAIL lat1_m_en_in_done cyc=%0d got=1 exp=0", c); else n_pass++;
      if (b1.i_ack) begin
        if (last >= 0) begin
          n_chk++; if (c - last != 3) $display("FAIL lat1_spacing cyc=%0d got=%0d exp=3", c, c - last); else n_pass++;
        end
        n_chk++; if (b1.i_rdata !== dflt(32'h08)) $display("FAIL lat1_rdata got=%h exp=%h", b1.i_rdata, dflt(32'h08)); else n_pass++;
        last = c;
        nack++;
      end
    end
    b1.i_req = 0;
    n_chk++; if (nack != 10) $display("FAIL lat1_ack_count got=%0d exp=10", nack); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_store_load();
    test_reset_midwrite();
    test_contention();
    test_random();
    test_lat1_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout passed=%0d total=%0d", n_pass, n_chk);
    $fatal(1, "bench did not complete");
  end

endmodule
